// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported data memory. It uses round-robin with
// registered grants, a burst lock, and a hold limit that bounds an unlocked owner's tenure.
module mem_port_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          M0_REQ,
    input  logic          M0_LOCK,
    input  logic          M0_WEN,
    input  logic [3:0]    M0_BE,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [DW-1:0] M0_WDATA,
    output logic          M0_GNT,
    output logic [DW-1:0] M0_RDATA,
    output logic          M0_RVALID,
    input  logic          M1_REQ,
    input  logic          M1_LOCK,
    input  logic          M1_WEN,
    input  logic [3:0]    M1_BE,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M1_WDATA,
    output logic          M1_GNT,
    output logic [DW-1:0] M1_RDATA,
    output logic          M1_RVALID,
    output logic          MEM_CSN,
    output logic          MEM_WEN,
    output logic [3:0]    MEM_BE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DOUT,
    input  logic [DW-1:0] MEM_DI
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            gnt0_r;
    logic            gnt1_r;
    logic            last_r;        // 0: M0 served last, 1: M1 served last
    logic            next_last_s;
    logic [HW-1:0]   hold_r;
    logic [HW-1:0]   next_hold_s;
    logic            other_req_s;
    logic            issue0_s;
    logic            issue1_s;
    logic            rd_vld_r;
    logic            rd_src_r;

    // Next-state, round-robin pointer and tenure counter evaluation
    always_comb begin
        next_state_s = state_r;
        next_last_s  = last_r;
        other_req_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (M0_REQ && (!M1_REQ || last_r)) begin
                    next_state_s = OWN0;
                end else if (M1_REQ) begin
                    next_state_s = OWN1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0: begin
                other_req_s = M1_REQ;
                if (!M0_REQ && !M0_LOCK) begin
                    next_last_s  = 1'b0;
                    next_state_s = M1_REQ ? OWN1 : IDLE;
                end else if (M0_LOCK) begin
                    next_state_s = OWN0;
                end else if (M1_REQ && (hold_r == HOLD_LAST)) begin
                    next_last_s  = 1'b0;
                    next_state_s = OWN1;
                end else begin
                    next_state_s = OWN0;
                end
            end
            OWN1: begin
                other_req_s = M0_REQ;
                if (!M1_REQ && !M1_LOCK) begin
                    next_last_s  = 1'b1;
                    next_state_s = M0_REQ ? OWN0 : IDLE;
                end else if (M1_LOCK) begin
                    next_state_s = OWN1;
                end else if (M0_REQ && (hold_r == HOLD_LAST)) begin
                    next_last_s  = 1'b1;
                    next_state_s = OWN0;
                end else begin
                    next_state_s = OWN1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        // Tenure only counts while the other side is waiting; lock does not stop it
        if (next_state_s != state_r) begin
            next_hold_s = {HW{1'b0}};
        end else if (other_req_s && (hold_r != HOLD_LAST)) begin
            next_hold_s = hold_r + HW'(1);
        end else if (other_req_s) begin
            next_hold_s = hold_r;
        end else begin
            next_hold_s = {HW{1'b0}};
        end
    end

    // Arbitration FSM with registered grants
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            last_r  <= 1'b1;
            hold_r  <= {HW{1'b0}};
        end else begin
            state_r <= next_state_s;
            gnt0_r  <= (next_state_s == OWN0);
            gnt1_r  <= (next_state_s == OWN1);
            last_r  <= next_last_s;
            hold_r  <= next_hold_s;
        end
    end

    assign issue0_s = gnt0_r && M0_REQ;
    assign issue1_s = gnt1_r && M1_REQ;

    // Memory command mux from the issuing owner; idle values otherwise
    always_comb begin
        MEM_CSN  = 1'b1;
        MEM_WEN  = 1'b1;
        MEM_BE   = 4'b0000;
        MEM_ADDR = {AW{1'b0}};
        MEM_DOUT = {DW{1'b0}};
        if (issue0_s) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = M0_WEN;
            MEM_BE   = M0_BE;
            MEM_ADDR = M0_ADDR;
            MEM_DOUT = M0_WDATA;
        end else if (issue1_s) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = M1_WEN;
            MEM_BE   = M1_BE;
            MEM_ADDR = M1_ADDR;
            MEM_DOUT = M1_WDATA;
        end else begin
            MEM_CSN  = 1'b1;
        end
    end

    // Remember who issued a read so data follows the issuer across a grant change
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_vld_r <= 1'b0;
            rd_src_r <= 1'b0;
        end else begin
            rd_vld_r <= (issue0_s || issue1_s) && MEM_WEN;
            rd_src_r <= issue1_s;
        end
    end

    assign M0_GNT    = gnt0_r;
    assign M1_GNT    = gnt1_r;
    assign M0_RVALID = rd_vld_r && !rd_src_r;
    assign M1_RVALID = rd_vld_r && rd_src_r;
    assign M0_RDATA  = M0_RVALID ? MEM_DI : {DW{1'b0}};
    assign M1_RDATA  = M1_RVALID ? MEM_DI : {DW{1'b0}};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters. M0 is the instruction-side fetch/refill path. M1 is the data cache's memory-side port.
- Round-robin arbitration with registered grants.
- Burst lock keeps the grant so a 4-word line refill is never split.
- Hold counter bounds the tenure of an unlocked owner.
- Sits between the cache controllers and the synchronous 1-cycle-latency memory.

Parameters:
AW, 12, word-address width
DW, 32, data width
MAX_HOLD, 8, max consecutive granted cycles for an unlocked owner while the other requester waits (>=2)

Ports:
CLK  in  1  clock, all state on rising edge
RSTn  in  1  asynchronous active-low reset
M0_REQ  in  1  M0 access request, active high
M0_LOCK  in  1  M0 burst lock; keeps grant while high
M0_WEN  in  1  M0 write enable negative (1=read)
M0_BE  in  4  M0 byte enables
M0_ADDR  in  AW  M0 word address
M0_WDATA  in  DW  M0 write data
M0_GNT  out  1  M0 owns port (registered)
M0_RDATA  out  DW  read data to M0
M0_RVALID  out  1  M0 read data valid
M1_REQ, M1_LOCK, M1_WEN, M1_BE, M1_ADDR, M1_WDATA  in  as M0  M1 request side
M1_GNT, M1_RDATA, M1_RVALID  out  as M0  M1 response side
MEM_CSN  out  1  memory chip select negative
MEM_WEN  out  1  memory write enable negative
MEM_BE  out  4  memory byte enables
MEM_ADDR  out  AW  memory word address
MEM_DOUT  out  DW  memory write data
MEM_DI  in  DW  memory read data, valid cycle after read issue

Behaviour:
- Reset state (RSTn low, asynchronous):
  - State IDLE.
  - Both GNT=0, both RVALID=0, both RDATA=0.
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DOUT=0.
  - last_served=M1, so M0 wins the first tie.
  - hold_cnt=0.
- FSM states: IDLE, OWN0, OWN1. GNTx is high exactly in OWNx.
- IDLE transitions:
  - Only one REQ high → grant that requester.
  - Both REQ high → grant the requester that is not last_served.
  - Neither REQ high → stay IDLE.
  - Grant latency: REQ sampled at edge k gives GNT high in cycle k+1.
- Issue rule: access issued in any cycle where GNTx=1 and Mx_REQ=1.
  - MEM_CSN=0; MEM_WEN, BE, ADDR, DOUT combinationally muxed from owner.
  - Otherwise MEM_* hold their reset values (CSN=1, WEN=1, others 0).
  - A requester must hold REQ and its command stable until it sees GNT.
  - One access per cycle; back-to-back issues allowed.
- Read return: a read issued at edge k gives Mx_RVALID=1 and Mx_RDATA=MEM_DI during cycle k+1.
  - Issuer recorded in a 1-bit pending register, so data returns to the issuer even if the grant has moved.
  - Non-issuer RVALID=0 and RDATA=0.
  - Writes produce no RVALID.
- OWNx transitions, evaluated at each edge in priority order:
  1. Mx_REQ=0 and Mx_LOCK=0 → release. Go to OWNy if My_REQ=1 (direct handover, no idle cycle), else IDLE. last_served=x.
  2. Mx_LOCK=1 → stay, even if Mx_REQ=0 (gap inside a burst).
  3. Mx_REQ=1, Mx_LOCK=0, My_REQ=1 and hold_cnt==MAX_HOLD-1 → preempt to OWNy. last_served=x.
  4. Otherwise stay.
- hold_cnt:
  - Increments each cycle in OWNx while My_REQ=1, saturating at MAX_HOLD-1.
  - Clears on any state change and whenever My_REQ=0.
  - Counts independently of LOCK; LOCK only blocks the preempt.
- A request dropped before being granted is legal. No access is issued for it.
- LOCK asserted without REQ while not the owner has no effect.
- Reset mid-burst: immediate return to reset state. Pending RVALID is dropped. The burst is not resumed.

Test Plan:
- Single M1 read: M1_REQ with ADDR=0x010 at edge 0 → M1_GNT cycle 1; MEM_CSN=0, MEM_ADDR=0x010 cycle 1; memory returns 0xDEADBEEF → M1_RVALID=1, M1_RDATA=0xDEADBEEF cycle 2; M0_RVALID stays 0.
- Tie after reset: both REQ at edge 0 → M0_GNT first. M0 drops REQ after 1 access → M1_GNT the next cycle with no idle gap. Repeat tie → M0 again, since last_served is now M1.
- Locked burst: M1 LOCK=1 with 4 reads 0x020–0x023 and a 2-cycle REQ gap, M0_REQ held the whole time → M1_GNT never drops, addresses issue in order. M0_GNT rises the cycle after M1 LOCK and REQ both fall.
- Preemption: M0 streams unlocked reads, M1_REQ rises → exactly MAX_HOLD=8 M0 grant cycles counted from M1_REQ rise, then M1_GNT. M0's last read RVALID still returns to M0 after the handover.
- Write path: M0 write ADDR=0x3FF, BE=4'b0011, WDATA=0x12345678 → MEM_WEN=0, MEM_BE=0011, MEM_DOUT=0x12345678 in the grant cycle; no RVALID.
- Async reset mid-burst: RSTn low between clock edges during M1 locked read → GNTs=0, MEM_CSN=1, RVALID=0 immediately. After release, M0 wins the first tie.
